// File: rtl/lsq_mem_port.sv
// ============================================================================
// Module      : lsq_mem_port
// Description : LSQ downstream stage. Checks alignment, drives a single-outstanding
//               req/ack memory port and returns load data over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsq_mem_port #(
  parameter int MEM_ADDR_WIDTH = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      clk,
  input  logic                      sync_rst_n,
  input  logic                      clk_en,
  input  logic                      lsq_valid,
  output logic                      lsq_ready,
  input  logic                      lsq_load_store,
  input  logic [MEM_ADDR_WIDTH-1:0] lsq_mem_addr,
  input  logic [DATA_WIDTH-1:0]     lsq_mem_data,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  input  logic                      mem_ack,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  output logic                      ld_valid,
  input  logic                      ld_ready,
  output logic [DATA_WIDTH-1:0]     ld_data,
  output logic                      st_done,
  output logic                      err_valid,
  output logic [1:0]                err_code
);

  localparam int c_OFS = $clog2(DATA_WIDTH / 8);
  localparam int c_CW  = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [MEM_ADDR_WIDTH-1:0] c_ALIGN_MASK = MEM_ADDR_WIDTH'((1 << c_OFS) - 1);
  localparam logic [c_CW-1:0] c_TMO_LAST =
      c_CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic [1:0] c_ERR_MISALIGN = 2'b01;
  localparam logic [1:0] c_ERR_TIMEOUT  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                    r_state, w_state;
  logic [c_CW-1:0]           r_cnt, w_cnt;
  logic                      r_mem_req, w_mem_req;
  logic                      r_mem_we, w_mem_we;
  logic [MEM_ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr;
  logic [DATA_WIDTH-1:0]     r_mem_wdata, w_mem_wdata;
  logic                      r_ld_valid, w_ld_valid;
  logic [DATA_WIDTH-1:0]     r_ld_data, w_ld_data;
  logic                      r_st_done, w_st_done;
  logic                      r_err_valid, w_err_valid;
  logic [1:0]                r_err_code, w_err_code;
  logic                      w_misaligned;
  logic                      w_timeout;

  assign w_misaligned = (lsq_mem_addr & c_ALIGN_MASK) != '0;
  assign w_timeout    = (TIMEOUT_CYCLES != 0) && (r_cnt == c_TMO_LAST);

  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_mem_req   = r_mem_req;
    w_mem_we    = r_mem_we;
    w_mem_addr  = r_mem_addr;
    w_mem_wdata = r_mem_wdata;
    w_ld_valid  = r_ld_valid;
    w_ld_data   = r_ld_data;
    w_st_done   = 1'b0;
    w_err_valid = 1'b0;
    w_err_code  = r_err_code;
    case (r_state)
      S_IDLE: begin
        if (lsq_valid) begin
          if (w_misaligned) begin
            w_err_valid = 1'b1;
            w_err_code  = c_ERR_MISALIGN;
          end else begin
            w_state     = S_REQ;
            w_mem_req   = 1'b1;
            w_mem_we    = lsq_load_store;
            w_mem_addr  = lsq_mem_addr;
            w_mem_wdata = lsq_load_store ? lsq_mem_data : '0;
          end
        end
      end
      S_REQ: begin
        // An ack on the final allowed cycle wins over the timeout.
        if (mem_ack) begin
          w_mem_req = 1'b0;
          w_cnt     = '0;
          if (r_mem_we) begin
            w_st_done = 1'b1;
            w_state   = S_IDLE;
          end else begin
            w_ld_data  = mem_rdata;
            w_ld_valid = 1'b1;
            w_state    = S_RESP;
          end
        end else if (w_timeout) begin
          w_mem_req   = 1'b0;
          w_cnt       = '0;
          w_err_valid = 1'b1;
          w_err_code  = c_ERR_TIMEOUT;
          w_state     = S_IDLE;
        end else begin
          w_cnt = r_cnt + c_CW'(1);
        end
      end
      S_RESP: begin
        if (ld_ready) begin
          w_ld_valid = 1'b0;
          w_state    = S_IDLE;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_ld_valid  <= 1'b0;
      r_ld_data   <= '0;
      r_st_done   <= 1'b0;
      r_err_valid <= 1'b0;
      r_err_code  <= 2'b00;
    end else if (clk_en) begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_mem_req   <= w_mem_req;
      r_mem_we    <= w_mem_we;
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
      r_ld_valid  <= w_ld_valid;
      r_ld_data   <= w_ld_data;
      r_st_done   <= w_st_done;
      r_err_valid <= w_err_valid;
      r_err_code  <= w_err_code;
    end
  end

  // Ready is masked during reset so nothing is offered before the state is known.
  assign lsq_ready = sync_rst_n && (r_state == S_IDLE);
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign ld_valid  = r_ld_valid;
  assign ld_data   = r_ld_data;
  assign st_done   = r_st_done;
  assign err_valid = r_err_valid;
  assign err_code  = r_err_code;

endmodule

`default_nettype wire

// File: tb/tb_lsq_mem_port.sv
// ============================================================================
// Module      : tb_lsq_mem_port
// Description : Transaction-level self-checking bench for lsq_mem_port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsq_mem_port;

  localparam int c_AW  = 32;
  localparam int c_DW  = 32;
  localparam int c_TMO = 6;

  logic            clk = 1'b0;
  logic            sync_rst_n, clk_en, lsq_valid, lsq_ready, lsq_load_store;
  logic [c_AW-1:0] lsq_mem_addr, mem_addr;
  logic [c_DW-1:0] lsq_mem_data, mem_wdata, mem_rdata, ld_data;
  logic            mem_req, mem_we, mem_ack, ld_valid, ld_ready, st_done, err_valid;
  logic [1:0]      err_code;

  int n_cmp = 0;
  int n_err = 0;

  // Expected observable state, maintained from the behavioural rules.
  logic            e_rdy, e_req, e_we, e_ldv, e_std, e_errv;
  logic [c_AW-1:0] e_addr;
  logic [c_DW-1:0] e_wdata, e_ldd;
  logic [1:0]      e_code;

  lsq_mem_port #(
    .MEM_ADDR_WIDTH(c_AW), .DATA_WIDTH(c_DW), .TIMEOUT_CYCLES(c_TMO)
  ) dut (
    .clk(clk), .sync_rst_n(sync_rst_n), .clk_en(clk_en),
    .lsq_valid(lsq_valid), .lsq_ready(lsq_ready), .lsq_load_store(lsq_load_store),
    .lsq_mem_addr(lsq_mem_addr), .lsq_mem_data(lsq_mem_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .st_done(st_done), .err_valid(err_valid), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic expect_all(input string t);
    chk({t, ".lsq_ready"}, 64'(lsq_ready), 64'(e_rdy));
    chk({t, ".mem_req"},   64'(mem_req),   64'(e_req));
    if (e_req) begin
      chk({t, ".mem_we"},    64'(mem_we),    64'(e_we));
      chk({t, ".mem_addr"},  64'(mem_addr),  64'(e_addr));
      chk({t, ".mem_wdata"}, 64'(mem_wdata), 64'(e_wdata));
    end
    chk({t, ".ld_valid"}, 64'(ld_valid), 64'(e_ldv));
    if (e_ldv) chk({t, ".ld_data"}, 64'(ld_data), 64'(e_ldd));
    chk({t, ".st_done"},   64'(st_done),   64'(e_std));
    chk({t, ".err_valid"}, 64'(err_valid), 64'(e_errv));
    chk({t, ".err_code"},  64'(err_code),  64'(e_code));
  endtask

  // n frozen cycles with clk_en low (nothing may move), then one enabled edge.
  task automatic tick(input int n);
    clk_en = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      expect_all("frozen");
    end
    clk_en = 1'b1;
    @(posedge clk); #1;
    e_std  = 1'b0;
    e_errv = 1'b0;
  endtask

  function automatic int rstall(input bit en);
    if (en && ($urandom_range(0, 3) == 0)) return int'($urandom_range(1, 3));
    return 0;
  endfunction

  // One queue entry end to end. wt = cycles before ack (>= c_TMO means never),
  // rd = cycles ld_ready stays low, stall_k = REQ cycle given a 3-cycle freeze.
  task automatic txn(input bit st, input logic [c_AW-1:0] addr, input logic [c_DW-1:0] data,
                     input logic [c_DW-1:0] rdata, input int wt, input int rd,
                     input int stall_k, input bit rnd);
    lsq_valid = 1'b1; lsq_load_store = st; lsq_mem_addr = addr; lsq_mem_data = data;
    tick(rstall(rnd));
    lsq_valid = 1'b0;
    lsq_mem_addr = $urandom; lsq_mem_data = $urandom;
    if (addr[1:0] != 2'b00) begin
      e_errv = 1'b1; e_code = 2'b01;
      expect_all("misalign");
      return;
    end
    e_req = 1'b1; e_we = st; e_addr = addr; e_wdata = st ? data : '0; e_rdy = 1'b0;
    expect_all("req_issue");
    for (int k = 0; k < c_TMO; k++) begin
      if (k == wt) begin mem_ack = 1'b1; mem_rdata = rdata; end
      tick((k == stall_k) ? 3 : rstall(rnd));
      mem_ack = 1'b0; mem_rdata = $urandom;
      if (k == wt) begin
        e_req = 1'b0;
        if (st) begin e_std = 1'b1; e_rdy = 1'b1; end
        else begin e_ldv = 1'b1; e_ldd = rdata; end
        expect_all("ack");
        break;
      end else if (k == c_TMO - 1) begin
        e_req = 1'b0; e_errv = 1'b1; e_code = 2'b10; e_rdy = 1'b1;
        expect_all("timeout");
        // A late ack in IDLE must have no effect.
        mem_ack = 1'b1; mem_rdata = $urandom;
        tick(0);
        mem_ack = 1'b0;
        expect_all("late_ack");
      end else begin
        expect_all("req_wait");
      end
    end
    if (!st && wt < c_TMO) begin
      ld_ready = 1'b0;
      for (int j = 0; j < rd; j++) begin
        tick(rstall(rnd));
        expect_all("ld_hold");
      end
      ld_ready = 1'b1;
      tick(rstall(rnd));
      ld_ready = 1'b0;
      e_ldv = 1'b0; e_rdy = 1'b1;
      expect_all("ld_taken");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    sync_rst_n = 1'b0; clk_en = 1'b1; lsq_valid = 1'b0; lsq_load_store = 1'b0;
    lsq_mem_addr = '0; lsq_mem_data = '0; mem_ack = 1'b0; mem_rdata = '0; ld_ready = 1'b0;
    e_rdy = 1'b0; e_req = 1'b0; e_we = 1'b0; e_ldv = 1'b0; e_std = 1'b0; e_errv = 1'b0;
    e_addr = '0; e_wdata = '0; e_ldd = '0; e_code = 2'b00;

    repeat (2) @(posedge clk);
    #1;
    expect_all("reset");
    sync_rst_n = 1'b1;
    e_rdy = 1'b1;
    #1;
    expect_all("post_reset");

    // Directed scenarios.
    txn(1'b1, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0, -1, 1'b0);
    txn(1'b0, 32'h204, 32'h0, 32'h12345678, 5, 3, -1, 1'b0);
    txn(1'b0, 32'h102, 32'h0, 32'h0, 0, 0, -1, 1'b0);
    tick(0);
    expect_all("misalign_clear");
    txn(1'b0, 32'h300, 32'h0, 32'h0, 99, 0, -1, 1'b0);
    txn(1'b1, 32'h400, 32'hCAFEF00D, 32'h0, 4, 0, 1, 1'b0);
    txn(1'b0, 32'h500, 32'h0, 32'hA5A5A5A5, 99, 0, 2, 1'b0);

    // Reset while a load is in REQ: abandoned, nothing comes back.
    lsq_valid = 1'b1; lsq_load_store = 1'b0; lsq_mem_addr = 32'h600;
    tick(0);
    lsq_valid = 1'b0;
    e_req = 1'b1; e_we = 1'b0; e_addr = 32'h600; e_wdata = '0; e_rdy = 1'b0;
    expect_all("pre_rst_req");
    tick(0);
    expect_all("pre_rst_req2");
    sync_rst_n = 1'b0;
    tick(0);
    e_req = 1'b0; e_ldv = 1'b0; e_code = 2'b00; e_rdy = 1'b0;
    expect_all("mid_reset");
    sync_rst_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'h0BAD0BAD;
    e_rdy = 1'b1;
    tick(0);
    mem_ack = 1'b0;
    expect_all("after_mid_reset");

    // Randomized traffic with random clk_en freezes.
    for (int t = 0; t < 60; t++) begin
      logic [c_AW-1:0] a;
      a = $urandom;
      if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
      else a[1:0] = 2'($urandom_range(1, 3));
      txn(1'($urandom_range(0, 1)), a, $urandom, $urandom,
          int'($urandom_range(0, 8)), int'($urandom_range(0, 3)), -1, 1'b1);
    end
    tick(0);
    expect_all("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
